// File: rtl/l2_pkg.sv
// l2_pkg: shared definitions for the L2 port arbiter.
//   DEFAULT_ADDR_W / DEFAULT_DATA_W : default block address / block data widths
//   state_t                         : arbiter FSM state encoding
//   GNT_I / GNT_D                   : grant id values (also the last_grant encoding)
package l2_pkg;

    localparam int DEFAULT_ADDR_W = 28;
    localparam int DEFAULT_DATA_W = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam logic GNT_I = 1'b0;
    localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/l2_port_arbiter_rr_arbiter2.sv
// rr_arbiter2: two-way round-robin grant decision, purely combinational.
//   req_i, req_d : pending requests from the I-cache and D-cache paths
//   last_grant   : requester granted most recently (GNT_I / GNT_D)
//   grant_valid  : at least one request is pending
//   grant_id     : requester to grant (meaningful only when grant_valid)
module rr_arbiter2
    import l2_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req_i | req_d;
        if (req_i && req_d) begin
            // On a tie the requester that did not win last time goes first,
            // which makes back-to-back grants strictly alternate.
            grant_id = ~last_grant;
        end else if (req_d) begin
            grant_id = GNT_D;
        end else begin
            grant_id = GNT_I;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: shares the single L2 port between the L1 I-cache and
// D-cache miss / write-back paths. One requester is served at a time; the
// L2 request is registered and the L2 response is returned only to the
// granted requester, with a one-cycle ready pulse.
//   clk, rst                          : clock, synchronous active-low reset
//   i_read, i_addr                    : I-cache block read request
//   i_rdata, i_ready                  : block and completion pulse to the I-cache
//   d_read, d_write, d_addr, d_wdata  : D-cache block read / write-back request
//   d_rdata, d_ready                  : block and completion pulse to the D-cache
//   l2_read, l2_write, l2_addr, l2_wdata : registered request to L2
//   l2_rdata, l2_ready                : L2 response
module l2_port_arbiter
    import l2_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_ready
);

    state_t state, state_next;
    logic   last_grant, last_grant_next;
    logic   grant_valid, grant_id;

    logic              l2_read_next, l2_write_next;
    logic [ADDR_W-1:0] l2_addr_next;
    logic [DATA_W-1:0] l2_wdata_next;
    logic [DATA_W-1:0] i_rdata_next, d_rdata_next;
    logic              i_ready_next, d_ready_next;

    rr_arbiter2 u_rr (
        .req_i       (i_read),
        .req_d       (d_read | d_write),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= GNT_I;   // D wins the first tie after reset
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next      = (grant_id == GNT_D) ? SERVE_D : SERVE_I;
                    last_grant_next = grant_id;
                end
            end
            SERVE_I, SERVE_D: begin
                if (l2_ready) state_next = RELEASE;
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        l2_read_next  = l2_read;
        l2_write_next = l2_write;
        l2_addr_next  = l2_addr;
        l2_wdata_next = l2_wdata;
        i_rdata_next  = i_rdata;
        d_rdata_next  = d_rdata;
        i_ready_next  = 1'b0;
        d_ready_next  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    if (grant_id == GNT_D) begin
                        // A write-back outranks a simultaneous D-side read.
                        l2_write_next = d_write;
                        l2_read_next  = ~d_write;
                        l2_addr_next  = d_addr;
                        l2_wdata_next = d_wdata;
                    end else begin
                        l2_write_next = 1'b0;
                        l2_read_next  = 1'b1;
                        l2_addr_next  = i_addr;
                        l2_wdata_next = '0;
                    end
                end
            end
            SERVE_I: begin
                if (l2_ready) begin
                    l2_read_next  = 1'b0;
                    l2_write_next = 1'b0;
                    i_rdata_next  = l2_rdata;
                    i_ready_next  = 1'b1;
                end
            end
            SERVE_D: begin
                if (l2_ready) begin
                    l2_read_next  = 1'b0;
                    l2_write_next = 1'b0;
                    // A write-back returns no block; keep the D-side data.
                    if (l2_read) d_rdata_next = l2_rdata;
                    d_ready_next  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            l2_read  <= 1'b0;
            l2_write <= 1'b0;
            l2_addr  <= '0;
            l2_wdata <= '0;
            i_rdata  <= '0;
            d_rdata  <= '0;
            i_ready  <= 1'b0;
            d_ready  <= 1'b0;
        end else begin
            l2_read  <= l2_read_next;
            l2_write <= l2_write_next;
            l2_addr  <= l2_addr_next;
            l2_wdata <= l2_wdata_next;
            i_rdata  <= i_rdata_next;
            d_rdata  <= d_rdata_next;
            i_ready  <= i_ready_next;
            d_ready  <= d_ready_next;
        end
    end

endmodule

// File: tb/tb_l2_port_arbiter.sv
// tb_l2_port_arbiter: directed, scoreboard-driven bench for l2_port_arbiter.
// Expected L2 transactions are queued when requests are raised and compared
// as the arbiter issues them; the bench also plays the L2 cache.
module tb_l2_port_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, l2_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, l2_rdata;
    logic [DW-1:0] i_rdata, d_rdata, l2_wdata;
    logic          i_ready, d_ready, l2_read, l2_write;
    logic [AW-1:0] l2_addr;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] exp_i = '0;
    logic [DW-1:0] exp_d = '0;

    typedef struct {
        bit            is_d;
        bit            wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } txn_t;

    txn_t sb[$];

    always #5 clk = ~clk;

    l2_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk      (clk),
        .rst      (rst),
        .i_read   (i_read),
        .i_addr   (i_addr),
        .i_rdata  (i_rdata),
        .i_ready  (i_ready),
        .d_read   (d_read),
        .d_write  (d_write),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_rdata  (d_rdata),
        .d_ready  (d_ready),
        .l2_read  (l2_read),
        .l2_write (l2_write),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
        .l2_rdata (l2_rdata),
        .l2_ready (l2_ready)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] rdata);
        txn_t t;
        t.is_d = is_d; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        sb.push_back(t);
    endtask

    // Wait for the next L2 request, compare it with the scoreboard head, answer
    // after lat cycles and check the returned block and ready pulse.
    // drop[0]/drop[1] release the I/D request in the RELEASE cycle; spur pulses
    // l2_ready during RELEASE.
    task automatic serve_one(input int exp_wait, input int lat, input bit [1:0] drop, input bit spur);
        txn_t t;
        int   waited;
        if (sb.size() == 0) begin
            total++; bad++;
            $error("FAIL sb_empty: observed=no entry expected=entry");
            return;
        end
        t = sb.pop_front();
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!(l2_read || l2_write) && waited < 50);
        if (!(l2_read || l2_write)) begin
            total++; bad++;
            $error("FAIL grant_timeout: observed=no request expected=request within 50 cycles");
            return;
        end
        if (exp_wait > 0) check("grant_latency", waited, exp_wait);
        check("l2_read", l2_read, !t.wr);
        check("l2_write", l2_write, t.wr);
        check("l2_addr", l2_addr, t.addr);
        if (t.wr) check("l2_wdata", l2_wdata, t.wdata);
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            check("hold_addr", l2_addr, t.addr);
            check("early_ready", {i_ready, d_ready}, 2'b00);
        end
        l2_rdata = t.rdata;
        l2_ready = 1'b1;
        @(negedge clk);
        l2_ready = 1'b0;
        if (t.is_d) begin
            if (!t.wr) exp_d = t.rdata;
        end else begin
            exp_i = t.rdata;
        end
        check("i_ready", i_ready, !t.is_d);
        check("d_ready", d_ready, t.is_d);
        check("l2_req_clear", {l2_read, l2_write}, 2'b00);
        check("i_rdata", i_rdata, exp_i);
        check("d_rdata", d_rdata, exp_d);
        if (drop[0]) i_read = 1'b0;
        if (drop[1]) begin
            d_read  = 1'b0;
            d_write = 1'b0;
        end
        if (spur) l2_ready = 1'b1;
        @(negedge clk);
        l2_ready = 1'b0;
        check("ready_pulse_end", {i_ready, d_ready}, 2'b00);
    endtask

    initial begin
        int waited;

        // Reset held with a request and a stray l2_ready present.
        rst      = 1'b0;
        i_read   = 1'b1;
        i_addr   = 28'h0000123;
        d_read   = 1'b0;
        d_write  = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        l2_rdata = '1;
        l2_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_l2_read", l2_read, 1'b0);
        check("rst_l2_write", l2_write, 1'b0);
        check("rst_l2_addr", l2_addr, '0);
        check("rst_l2_wdata", l2_wdata, '0);
        check("rst_readies", {i_ready, d_ready}, 2'b00);
        check("rst_i_rdata", i_rdata, '0);
        check("rst_d_rdata", d_rdata, '0);
        rst      = 1'b1;
        l2_ready = 1'b0;
        push(1'b0, 1'b0, 28'h0000123, '0, 128'h0000_0000_0000_0000_0000_0000_0000_AAAA);
        serve_one(1, 2, 2'b01, 1'b0);

        // Single I read with a 5-cycle L2 latency.
        i_addr = 28'h0000040;
        i_read = 1'b1;
        push(1'b0, 1'b0, 28'h0000040, '0, 128'hDEADBEEF_00000000_00000000_00000001);
        serve_one(1, 5, 2'b01, 1'b0);

        // Simultaneous requests: D first, then I.
        i_addr = 28'h0000100;
        d_addr = 28'h0000200;
        i_read = 1'b1;
        d_read = 1'b1;
        push(1'b1, 1'b0, 28'h0000200, '0, 128'h0000_1111_2222_3333_4444_5555_6666_7777);
        push(1'b0, 1'b0, 28'h0000100, '0, 128'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF);
        serve_one(1, 2, 2'b10, 1'b0);
        serve_one(1, 3, 2'b01, 1'b0);

        // Both requesting continuously: grants alternate D, I, D, I.
        i_read = 1'b1;
        d_read = 1'b1;
        push(1'b1, 1'b0, 28'h0000200, '0, 128'h1);
        push(1'b0, 1'b0, 28'h0000100, '0, 128'h2);
        push(1'b1, 1'b0, 28'h0000200, '0, 128'h3);
        push(1'b0, 1'b0, 28'h0000100, '0, 128'h4);
        serve_one(1, 1, 2'b00, 1'b0);
        serve_one(1, 1, 2'b00, 1'b0);
        serve_one(1, 1, 2'b00, 1'b0);
        serve_one(1, 1, 2'b11, 1'b0);

        // D write-back with d_read also high: write wins, d_rdata unchanged.
        d_addr  = 28'h00003FF;
        d_wdata = 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
        d_write = 1'b1;
        d_read  = 1'b1;
        push(1'b1, 1'b1, 28'h00003FF, 128'h1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978,
             128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0);
        serve_one(1, 2, 2'b10, 1'b0);

        // Spurious l2_ready in IDLE.
        l2_ready = 1'b1;
        @(negedge clk);
        l2_ready = 1'b0;
        @(negedge clk);
        check("spur_idle_ready", {i_ready, d_ready}, 2'b00);
        check("spur_idle_req", {l2_read, l2_write}, 2'b00);

        // Spurious l2_ready in RELEASE, then a normal D read.
        i_addr = 28'h0000AB0;
        i_read = 1'b1;
        push(1'b0, 1'b0, 28'h0000AB0, '0, 128'h5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A_5A5A);
        serve_one(1, 2, 2'b01, 1'b1);
        check("spur_rel_req", {l2_read, l2_write}, 2'b00);
        d_addr = 28'h0000CD0;
        d_read = 1'b1;
        push(1'b1, 1'b0, 28'h0000CD0, '0, 128'hA5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5);
        serve_one(1, 2, 2'b10, 1'b0);

        // Reset in the middle of a D write-back.
        d_addr  = 28'h0000055;
        d_wdata = 128'hFEED;
        d_write = 1'b1;
        waited  = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!l2_write && waited < 50);
        check("mid_grant_write", l2_write, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_req", {l2_read, l2_write}, 2'b00);
        check("mid_rst_d_ready", d_ready, 1'b0);
        rst     = 1'b1;
        d_write = 1'b0;
        exp_i   = '0;
        exp_d   = '0;
        @(negedge clk);
        l2_rdata = 128'hC0FFEE;
        l2_ready = 1'b1;
        @(negedge clk);
        l2_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("mid_late_ready", {i_ready, d_ready}, 2'b00);
            @(negedge clk);
        end
        check("mid_d_rdata", d_rdata, exp_d);

        // First tie after reset goes to D.
        i_addr = 28'h0000111;
        d_addr = 28'h0000222;
        i_read = 1'b1;
        d_read = 1'b1;
        push(1'b1, 1'b0, 28'h0000222, '0, 128'h7);
        push(1'b0, 1'b0, 28'h0000111, '0, 128'h8);
        serve_one(1, 2, 2'b10, 1'b0);
        serve_one(1, 2, 2'b01, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
